// File: rtl/flu_issue_unit.sv
// flu_issue_unit: request FIFO plus a four-state issue FSM that encodes each FP
// operation into the FLU control word. The word is held for the operation's
// latency, and then the unit reports completion with the destination register.
// Optional feature macro: FLU_ISSUE_BYPASS_EN. When it is defined, a request
// that arrives at an empty, idle unit skips the FIFO and loads control on the
// acceptance edge.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on the FIFO count, so a full
// FIFO never accepts, even on an edge that also pops.
module flu_issue_unit #(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 4,
  parameter int MUL_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_frd,
  output logic [31:0] control,
  output logic        issue_valid,
  output logic        done_valid,
  output logic [4:0]  done_frd,
  output logic        err_illegal,
  output logic        busy
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int MAXLAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int LW     = $clog2(MAXLAT + 1);
  localparam logic [31:0] CONTROL_RST = 32'h0000_004B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The FSM state is a named signal so that checkers can bind to it directly.
  state_t state;

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] cnt;
  logic [4:0]    cur_frd;

  logic          fifo_empty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          take;
  logic [19:0]   head;
  logic [19:0]   taken;
  logic          taken_legal;
  logic [LW-1:0] taken_lat;

  // Fixed field layout: op | 00 | rs2 | rs1 | 000 | frd | 1001011.
  function automatic logic [31:0] encode(input logic [19:0] f);
    return {f[19:15], 2'b00, f[9:5], f[14:10], 3'b000, f[4:0], 7'b1001011};
  endfunction

  assign fifo_empty = (count == '0);
  assign req_ready  = (count < CW'(DEPTH));
  assign push_req   = req_valid & req_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) | ~fifo_empty;

`ifdef FLU_ISSUE_BYPASS_EN
  // An empty, idle unit takes the incoming request straight into the FSM.
  assign bypass = (state == IDLE) & fifo_empty & push_req;
`else
  assign bypass = 1'b0;
`endif

  // The FSM can take a new entry only from IDLE or DONE.
  assign pop         = ((state == IDLE) | (state == DONE)) & ~fifo_empty;
  assign push        = push_req & ~bypass;
  assign take        = pop | bypass;
  assign taken       = bypass ? {req_op, req_rs1, req_rs2, req_frd} : head;
  assign taken_legal = (taken[19:17] == 3'b000);
  assign taken_lat   = taken[16] ? LW'(MUL_LAT) : LW'(ADD_LAT);

  // FIFO storage write; the array holds data only and is not reset.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= {req_op, req_rs1, req_rs2, req_frd};
  end

  // FIFO pointers and occupancy. The pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Issue FSM with registered control word, pulses and completion tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      control     <= CONTROL_RST;
      issue_valid <= 1'b0;
      done_valid  <= 1'b0;
      err_illegal <= 1'b0;
      done_frd    <= '0;
      cur_frd     <= '0;
    end else begin
      issue_valid <= 1'b0;
      done_valid  <= 1'b0;
      err_illegal <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (take) begin
            if (taken_legal) begin
              control     <= encode(taken);
              cnt         <= taken_lat;
              cur_frd     <= taken[4:0];
              issue_valid <= 1'b1;
              state       <= ISSUE;
            end else begin
              // Illegal op: discard it and keep the previously issued word.
              err_illegal <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // Leave on count 1, so WAIT lasts exactly the latency.
          if (cnt <= LW'(1)) begin
            cnt        <= '0;
            done_valid <= 1'b1;
            done_frd   <= cur_frd;
            state      <= DONE;
          end else begin
            cnt <= cnt - LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
